// File: rtl/prbs9_checker.sv
// PRBS9 (x^9+x^5+1) receive checker: hunts for a nonzero seed, verifies the sequence,
// then free-runs a local reference in LOCKED while counting bit errors.
module prbs9_checker #(
    parameter int unsigned LOCK_GOOD = 16,
    parameter int unsigned LOSS_ERR  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        clear_cnt,
    output logic [1:0]  state,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [15:0] bit_count
);

    localparam int unsigned GW = $clog2(LOCK_GOOD + 1);
    localparam int unsigned EW = $clog2(LOSS_ERR + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t         r_state;
    logic [8:0]     r_sr;
    logic [3:0]     r_fill;
    logic [GW-1:0]  r_good;
    logic [4:0]     r_win;
    logic [EW-1:0]  r_win_err;
    logic           r_locked;
    logic           r_err_pulse;
    logic [15:0]    r_err_cnt;
    logic [15:0]    r_bit_cnt;

    logic           w_pred;
    logic           w_mismatch;
    logic [8:0]     w_sr_in;
    logic [3:0]     w_fill_inc;
    logic [GW-1:0]  w_good_inc;
    logic [EW-1:0]  w_win_err_inc;
    logic [15:0]    w_err_cnt_inc;
    logic [15:0]    w_bit_cnt_inc;

    assign w_pred        = r_sr[8] ^ r_sr[4];
    assign w_mismatch    = bit_in ^ w_pred;
    assign w_sr_in       = {r_sr[7:0], bit_in};
    assign w_fill_inc    = (r_fill == 4'd9) ? 4'd9 : r_fill + 4'd1;
    assign w_good_inc    = r_good + GW'(1);
    assign w_win_err_inc = r_win_err + EW'(w_mismatch);
    assign w_err_cnt_inc = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
    assign w_bit_cnt_inc = (r_bit_cnt == 16'hFFFF) ? r_bit_cnt : r_bit_cnt + 16'd1;

    // Checker state machine and counters; only valid bits advance anything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_HUNT;
            r_sr        <= 9'd0;
            r_fill      <= 4'd0;
            r_good      <= '0;
            r_win       <= 5'd0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= 16'd0;
            r_bit_cnt   <= 16'd0;
        end else begin
            r_err_pulse <= 1'b0;
            if (bit_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        r_sr   <= w_sr_in;
                        r_fill <= w_fill_inc;
                        if (w_fill_inc == 4'd9 && w_sr_in != 9'd0) begin
                            r_state <= ST_SYNC;
                            r_good  <= '0;
                        end
                    end
                    ST_SYNC: begin
                        r_sr <= w_sr_in;
                        if (w_mismatch) begin
                            r_state <= ST_HUNT;
                            r_fill  <= 4'd1;
                            r_good  <= '0;
                        end else begin
                            r_good <= w_good_inc;
                            if (w_good_inc == GW'(LOCK_GOOD)) begin
                                r_state   <= ST_LOCKED;
                                r_locked  <= 1'b1;
                                r_win     <= 5'd0;
                                r_win_err <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        // Self-running reference: one bad bit never corrupts later predictions.
                        r_sr      <= {r_sr[7:0], w_pred};
                        r_win     <= r_win + 5'd1;
                        r_bit_cnt <= w_bit_cnt_inc;
                        if (w_mismatch) begin
                            r_err_pulse <= 1'b1;
                            r_err_cnt   <= w_err_cnt_inc;
                        end
                        if (w_win_err_inc == EW'(LOSS_ERR)) begin
                            r_state   <= ST_HUNT;
                            r_locked  <= 1'b0;
                            r_fill    <= 4'd0;
                            r_good    <= '0;
                            r_win     <= 5'd0;
                            r_win_err <= '0;
                        end else if (r_win == 5'd31) begin
                            r_win_err <= '0;
                        end else begin
                            r_win_err <= w_win_err_inc;
                        end
                    end
                    default: begin
                        r_state  <= ST_HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
            if (clear_cnt) begin
                r_err_cnt <= 16'd0;
                r_bit_cnt <= 16'd0;
            end
        end
    end

    assign state     = r_state;
    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_cnt;
    assign bit_count = r_bit_cnt;

endmodule

// File: tb/tb_prbs9_checker.sv
// Bench for prbs9_checker: scenario tasks with a queue-based reference model of the checker rules.
module tb_prbs9_checker;

    localparam int unsigned LOCK_GOOD = 16;
    localparam int unsigned LOSS_ERR  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        bit_in;
    logic        bit_valid;
    logic        clear_cnt;
    logic [1:0]  state;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] bit_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prbs9_checker #(.LOCK_GOOD(LOCK_GOOD), .LOSS_ERR(LOSS_ERR)) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear_cnt(clear_cnt), .state(state), .locked(locked),
        .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
    );

    // Transmit sequence: one full period, b[n] = b[n-9] ^ b[n-5], seeded with nine ones.
    bit prbs[511];
    int tx_idx = 0;

    function automatic bit get_tx();
        bit b;
        b = prbs[tx_idx % 511];
        tx_idx++;
        return b;
    endfunction

    // Reference model: history queue holds the last 9 bits, oldest first.
    int m_mode, m_fill, m_good, m_wcnt, m_werr, m_ecnt, m_bcnt;
    bit m_epulse;
    bit m_hist[$];

    task automatic mdl_reset();
        m_mode = 0; m_fill = 0; m_good = 0; m_wcnt = 0; m_werr = 0;
        m_ecnt = 0; m_bcnt = 0; m_epulse = 0;
        m_hist.delete();
        for (int i = 0; i < 9; i++) m_hist.push_back(1'b0);
    endtask

    task automatic mdl_push(input bit b);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
    endtask

    task automatic mdl_step(input bit b, input bit v, input bit c);
        bit p;
        bit nz;
        m_epulse = 0;
        if (v) begin
            p = m_hist[0] ^ m_hist[4];
            if (m_mode == 0) begin
                mdl_push(b);
                m_fill = (m_fill < 9) ? m_fill + 1 : 9;
                nz = 0;
                foreach (m_hist[i]) nz |= m_hist[i];
                if (m_fill == 9 && nz) begin m_mode = 1; m_good = 0; end
            end else if (m_mode == 1) begin
                mdl_push(b);
                if (b != p) begin
                    m_mode = 0; m_fill = 1; m_good = 0;
                end else begin
                    m_good++;
                    if (m_good == LOCK_GOOD) begin m_mode = 2; m_wcnt = 0; m_werr = 0; end
                end
            end else begin
                mdl_push(p);
                if (m_bcnt < 65535) m_bcnt++;
                if (b != p) begin
                    m_epulse = 1;
                    if (m_ecnt < 65535) m_ecnt++;
                    m_werr++;
                end
                m_wcnt++;
                if (m_werr == LOSS_ERR) begin
                    m_mode = 0; m_fill = 0; m_good = 0; m_wcnt = 0; m_werr = 0;
                end else if (m_wcnt == 32) begin
                    m_wcnt = 0; m_werr = 0;
                end
            end
        end
        if (c) begin m_ecnt = 0; m_bcnt = 0; end
    endtask

    function automatic logic [35:0] mdl_vec();
        return {2'(m_mode), (m_mode == 2), m_epulse, 16'(m_ecnt), 16'(m_bcnt)};
    endfunction

    task automatic drive(input bit b, input bit v, input bit c);
        @(negedge clk);
        bit_in = b; bit_valid = v; clear_cnt = c;
        @(posedge clk);
        mdl_step(b, v, c);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; bit_valid = 1'b0; clear_cnt = 1'b0; bit_in = 1'b0;
        mdl_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic lock_up();
        for (int i = 0; i < 25; i++) drive(get_tx(), 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; bit_valid = 1'b1; clear_cnt = 1'b0; bit_in = 1'b1;
        mdl_reset();
        @(posedge clk); #1;
        checks++;
        if ({state, locked, err_pulse, err_count, bit_count} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {state, locked, err_pulse, err_count, bit_count}, 36'd0);
        end
        @(negedge clk);
        reset = 1'b1; bit_valid = 1'b0;
    endtask

    task automatic test_lock_clean();
        logic [1:0] es;
        do_reset();
        for (int i = 1; i <= 35; i++) begin
            drive(get_tx(), 1'b1, 1'b0);
            es = (i < 9) ? 2'd0 : (i < 25) ? 2'd1 : 2'd2;
            checks++;
            if (state !== es) begin
                failures++;
                $display("FAIL lock_state bit%0d: got %0d expected %0d", i, state, es);
            end
            checks++;
            if ({state, locked, err_pulse, err_count, bit_count} !== mdl_vec()) begin
                failures++;
                $display("FAIL lock_model bit%0d: got %h expected %h", i,
                         {state, locked, err_pulse, err_count, bit_count}, mdl_vec());
            end
        end
        checks++;
        if ({locked, err_count, bit_count} !== {1'b1, 16'd0, 16'd10}) begin
            failures++;
            $display("FAIL lock_counts: got %h expected %h",
                     {locked, err_count, bit_count}, {1'b1, 16'd0, 16'd10});
        end
    endtask

    task automatic test_single_err();
        drive(~get_tx(), 1'b1, 1'b0);
        checks++;
        if ({err_pulse, locked, err_count} !== {1'b1, 1'b1, 16'd1}) begin
            failures++;
            $display("FAIL single_err_hit: got %h expected %h",
                     {err_pulse, locked, err_count}, {1'b1, 1'b1, 16'd1});
        end
        for (int i = 0; i < 10; i++) begin
            drive(get_tx(), 1'b1, 1'b0);
            checks++;
            if ({err_pulse, locked, err_count} !== {1'b0, 1'b1, 16'd1}) begin
                failures++;
                $display("FAIL single_err_after%0d: got %h expected %h", i,
                         {err_pulse, locked, err_count}, {1'b0, 1'b1, 16'd1});
            end
        end
    endtask

    task automatic test_loss();
        do_reset();
        lock_up();
        for (int k = 0; k <= 6; k++) begin
            drive((k % 2 == 0) ? ~get_tx() : get_tx(), 1'b1, 1'b0);
            checks++;
            if ({state, locked, err_pulse, err_count, bit_count} !== mdl_vec()) begin
                failures++;
                $display("FAIL loss_model k%0d: got %h expected %h", k,
                         {state, locked, err_pulse, err_count, bit_count}, mdl_vec());
            end
        end
        checks++;
        if ({state, locked, err_count, bit_count} !== {2'd0, 1'b0, 16'd4, 16'd7}) begin
            failures++;
            $display("FAIL loss_drop: got %h expected %h",
                     {state, locked, err_count, bit_count}, {2'd0, 1'b0, 16'd4, 16'd7});
        end
        for (int i = 1; i <= 25; i++) begin
            drive(get_tx(), 1'b1, 1'b0);
            if (i == 24 || i == 25) begin
                checks++;
                if (state !== ((i == 25) ? 2'd2 : 2'd1)) begin
                    failures++;
                    $display("FAIL loss_relock bit%0d: got %0d expected %0d", i, state,
                             (i == 25) ? 2 : 1);
                end
            end
        end
        checks++;
        if (err_count !== 16'd4) begin
            failures++;
            $display("FAIL loss_err_hold: got %0d expected 4", err_count);
        end
    endtask

    task automatic test_zero();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            checks++;
            if ({state, locked, err_pulse, err_count, bit_count} !== 36'd0) begin
                failures++;
                $display("FAIL zero_stream bit%0d: got %h expected 0", i,
                         {state, locked, err_pulse, err_count, bit_count});
            end
        end
    endtask

    task automatic test_clear_with_err();
        do_reset();
        lock_up();
        for (int i = 0; i < 5; i++) drive(get_tx(), 1'b1, 1'b0);
        drive(~get_tx(), 1'b1, 1'b1);
        checks++;
        if ({err_pulse, err_count, bit_count, state} !== {1'b1, 16'd0, 16'd0, 2'd2}) begin
            failures++;
            $display("FAIL clear_with_err: got %h expected %h",
                     {err_pulse, err_count, bit_count, state}, {1'b1, 16'd0, 16'd0, 2'd2});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        lock_up();
        for (int e = 0; e < 3; e++) begin
            drive(~get_tx(), 1'b1, 1'b0);
            drive(get_tx(), 1'b1, 1'b0);
            drive(get_tx(), 1'b1, 1'b0);
        end
        checks++;
        if ({locked, err_count} !== {1'b1, 16'd3}) begin
            failures++;
            $display("FAIL async_pre: got %h expected %h", {locked, err_count}, {1'b1, 16'd3});
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({state, locked, err_pulse, err_count, bit_count} !== 36'd0) begin
            failures++;
            $display("FAIL async_reset: got %h expected 0",
                     {state, locked, err_pulse, err_count, bit_count});
        end
        mdl_reset();
        bit_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            drive(get_tx(), 1'b1, 1'b0);
            if (i >= 24) begin
                checks++;
                if (locked !== (i == 25)) begin
                    failures++;
                    $display("FAIL async_relock bit%0d: got %0b expected %0b", i, locked, i == 25);
                end
            end
        end
    endtask

    task automatic test_gaps();
        bit seq[80];
        int  g_ecnt, g_bcnt;
        for (int i = 0; i < 80; i++)
            seq[i] = get_tx() ^ ((i >= 30 && $urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        do_reset();
        for (int i = 0; i < 80; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                drive(1'($urandom), 1'b0, 1'b0);
                checks++;
                if ({state, locked, err_pulse, err_count, bit_count} !== mdl_vec()) begin
                    failures++;
                    $display("FAIL gaps_idle i%0d: got %h expected %h", i,
                             {state, locked, err_pulse, err_count, bit_count}, mdl_vec());
                end
            end
            drive(seq[i], 1'b1, 1'b0);
            checks++;
            if ({state, locked, err_pulse, err_count, bit_count} !== mdl_vec()) begin
                failures++;
                $display("FAIL gaps_valid i%0d: got %h expected %h", i,
                         {state, locked, err_pulse, err_count, bit_count}, mdl_vec());
            end
        end
        g_ecnt = m_ecnt;
        g_bcnt = m_bcnt;
        do_reset();
        for (int i = 0; i < 80; i++) drive(seq[i], 1'b1, 1'b0);
        checks++;
        if ({err_count, bit_count} !== {16'(g_ecnt), 16'(g_bcnt)}) begin
            failures++;
            $display("FAIL gaps_vs_continuous: got %h expected %h",
                     {err_count, bit_count}, {16'(g_ecnt), 16'(g_bcnt)});
        end
    endtask

    task automatic test_random();
        bit v, e, c;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 9) < 8);
            e = ($urandom_range(0, 99) < 3);
            c = ($urandom_range(0, 99) == 0);
            drive(v ? (get_tx() ^ e) : 1'($urandom), v, c);
            checks++;
            if ({state, locked, err_pulse, err_count, bit_count} !== mdl_vec()) begin
                failures++;
                $display("FAIL random i%0d: got %h expected %h", i,
                         {state, locked, err_pulse, err_count, bit_count}, mdl_vec());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 511; i++)
            prbs[i] = (i < 9) ? 1'b1 : (prbs[i-9] ^ prbs[i-5]);
        reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear_cnt = 1'b0;
        mdl_reset();
        test_reset();
        test_lock_clean();
        test_single_err();
        test_loss();
        test_zero();
        test_clear_with_err();
        test_async_reset();
        test_gaps();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
